chunked_add_seq: RTL
====================

CHUNKED_ADD_SEQ -- requirements
Module: chunked_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port cin, input, 1 bit: carry into chunk 0. Subtraction is done as b inverted with cin=1.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out and cout hold a completed result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port out, output, WIDTH bits: the sum a+b+cin modulo 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1 bit: the carry out of the most significant chunk.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 When in_valid and in_ready are both 1 at a rising edge, the block SHALL register a, b and cin (cin into the carry register), clear the chunk index to 0, and enter BUSY.
REQ-017 Each BUSY cycle SHALL add chunk[idx] of a, chunk[idx] of b and the carry register, write the low CHUNK bits into result chunk idx, store the carry-out, and increment idx.
REQ-018 When idx = NCHUNK-1 is processed, the FSM SHALL enter DONE and cout SHALL take that chunk's carry-out; BUSY therefore lasts exactly NCHUNK cycles.
REQ-019 out_valid SHALL rise exactly NCHUNK rising edges after the accept edge; for the defaults that is 4 cycles.
REQ-020 In DONE, out_valid SHALL be 1 and out and cout SHALL be stable until out_ready is sampled 1; the FSM then returns to IDLE.
REQ-021 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-022 Changes on a, b or cin after the accept edge SHALL NOT affect the result.
REQ-023 out and cout SHALL hold the last completed result in IDLE until the next result overwrites them chunk by chunk during BUSY.
REQ-024 With in_valid and out_ready held at 1, an accept SHALL occur every NCHUNK+2 cycles.
REQ-025 out_ready while in IDLE or BUSY SHALL have no effect.

Reset
REQ-026 When rst is 1 at a rising edge, the block SHALL enter IDLE and set in_ready=1, out_valid=0, out=0, cout=0, idx=0 and carry=0.
REQ-027 A reset during BUSY or DONE SHALL abandon the operation: no out_valid pulse for it, and in_ready=1 on the next cycle.
REQ-028 If rst and in_valid are both 1 at the same edge, the operands SHALL NOT be accepted.

Structure
REQ-029 A shared package chunked_add_seq_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the default WIDTH and CHUNK constants.
REQ-030 One combinational sub-module, chunk_adder (CHUNK-bit a, b, cin; CHUNK-bit sum, cout), SHALL be instantiated once and time-shared across chunks.

Verification
REQ-031 Test 1: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out=0x00000000, cout=1, with out_valid exactly 4 cycles after accept.
REQ-032 Test 2: a=0x12345678, b=0x11111111, cin=1 -> out=0x2345678A, cout=0.
REQ-033 Test 3: a=0x000000FF, b=0x00000001, cin=0 -> out=0x00000100 (carry crosses a chunk boundary); then a=0x00000005, b=~0x00000003, cin=1 -> out=0x00000002, cout=1.
REQ-034 Test 4: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, out is unchanged, in_ready=0, and a pending in_valid is not accepted until 1 cycle after out_ready.
REQ-035 Test 5: assert rst in the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, out=0, and no result for that operation ever appears.
REQ-036 Test 6: in_valid=1 and out_ready=1 held continuously with 10 operand pairs -> 10 correct results, accepts spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/chunked_add_seq_pkg.sv
// Shared types and defaults for the chunked sequential adder.
package chunked_add_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/chunked_add_seq_chunk_adder.sv
// Combinational CHUNK-bit adder slice, time-shared by chunked_add_seq.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum   = total[CHUNK-1:0];
    cout  = total[CHUNK];
  end

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle adder: one CHUNK-wide slice per cycle, valid/ready on both sides.
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_sum;
  logic               chunk_cout;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // The previous result stays visible in IDLE and is overwritten one slice at a time.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDX_W'(i)) begin
            out_d[i*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          cout_d      = chunk_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;

endmodule
